// File: rtl/piece_controller.sv
// Falling-block sequencer: owns the block position, latches tick/move/drop requests and
// legality-checks every candidate cell against the well before committing or locking.
module piece_controller #(
    parameter int WELL_X    = 50,
    parameter int WELL_Y    = 120,
    parameter int BLOCK_PX  = 16,
    parameter int COLS      = 10,
    parameter int ROWS      = 20,
    parameter int SPAWN_COL = 4
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        tick,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        hard_drop,
    output logic        chk_valid,
    output logic [3:0]  chk_col,
    output logic [4:0]  chk_row,
    input  logic        chk_ready,
    input  logic        chk_blocked,
    output logic        lock_valid,
    input  logic        lock_ready,
    output logic [3:0]  cur_col,
    output logic [4:0]  cur_row,
    output logic [10:0] x_pos,
    output logic [10:0] y_pos,
    output logic [15:0] pieces_locked,
    output logic        game_over,
    output logic [2:0]  fsm_state
);
    // Handshakes: a transfer happens on a cycle where valid and ready are both high; valid,
    // and the address qualifying it, hold steady until then.
    typedef enum logic [2:0] {
        S_SPAWN    = 3'd0,
        S_WAIT     = 3'd1,
        S_CHECK    = 3'd2,
        S_LOCK     = 3'd3,
        S_GAMEOVER = 3'd4
    } state_t;

    typedef enum logic [1:0] {OP_SPAWN, OP_DOWN, OP_LEFT, OP_RIGHT} op_t;

    localparam logic [3:0]  COL_SPAWN = 4'(SPAWN_COL);
    localparam logic [3:0]  COL_MAX   = 4'(COLS - 1);
    localparam logic [4:0]  ROW_MAX   = 5'(ROWS - 1);
    localparam logic [10:0] X0        = 11'(WELL_X);
    localparam logic [10:0] Y0        = 11'(WELL_Y);
    localparam logic [10:0] PX        = 11'(BLOCK_PX);

    state_t     state;
    op_t        op;
    logic [3:0] cand_col;
    logic [4:0] cand_row;
    logic       pend_down, pend_left, pend_right, pend_drop, drop_mode;
    logic       oob;

    assign chk_col   = cand_col;
    assign chk_row   = cand_row;
    assign fsm_state = state;
    assign x_pos     = X0 + PX * {7'd0, cur_col};
    assign y_pos     = Y0 + PX * {6'd0, cur_row};

    always_comb begin
        oob = 1'b0;
        case (op)
            OP_LEFT:  oob = (cur_col == 4'd0);
            OP_RIGHT: oob = (cur_col == COL_MAX);
            OP_DOWN:  oob = (cur_row == ROW_MAX);
            default:  oob = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state         <= S_SPAWN;
            op            <= OP_SPAWN;
            cand_col      <= COL_SPAWN;
            cand_row      <= 5'd0;
            cur_col       <= COL_SPAWN;
            cur_row       <= 5'd0;
            chk_valid     <= 1'b0;
            lock_valid    <= 1'b0;
            pieces_locked <= 16'd0;
            game_over     <= 1'b0;
            pend_down     <= 1'b0;
            pend_left     <= 1'b0;
            pend_right    <= 1'b0;
            pend_drop     <= 1'b0;
            drop_mode     <= 1'b0;
        end else begin
            case (state)
                S_SPAWN: begin
                    op       <= OP_SPAWN;
                    cand_col <= COL_SPAWN;
                    cand_row <= 5'd0;
                    state    <= S_CHECK;
                end
                S_WAIT: begin
                    // A drop in progress owns the block; other requests wait for the next piece.
                    if (drop_mode || pend_drop || pend_down) begin
                        if (!drop_mode && pend_drop) begin
                            pend_drop <= 1'b0;
                            drop_mode <= 1'b1;
                        end else if (!drop_mode) begin
                            pend_down <= 1'b0;
                        end
                        op       <= OP_DOWN;
                        cand_col <= cur_col;
                        cand_row <= cur_row + 5'd1;
                        state    <= S_CHECK;
                    end else if (pend_left) begin
                        pend_left <= 1'b0;
                        op        <= OP_LEFT;
                        cand_col  <= cur_col - 4'd1;
                        cand_row  <= cur_row;
                        state     <= S_CHECK;
                    end else if (pend_right) begin
                        pend_right <= 1'b0;
                        op         <= OP_RIGHT;
                        cand_col   <= cur_col + 4'd1;
                        cand_row   <= cur_row;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!chk_valid) begin
                        // Walls and floor are resolved locally without querying the well.
                        if (oob) begin
                            if (op == OP_DOWN) begin
                                drop_mode  <= 1'b0;
                                lock_valid <= 1'b1;
                                state      <= S_LOCK;
                            end else begin
                                state <= S_WAIT;
                            end
                        end else begin
                            chk_valid <= 1'b1;
                        end
                    end else if (chk_ready) begin
                        chk_valid <= 1'b0;
                        if (!chk_blocked) begin
                            cur_col <= cand_col;
                            cur_row <= cand_row;
                            state   <= S_WAIT;
                        end else if (op == OP_DOWN) begin
                            drop_mode  <= 1'b0;
                            lock_valid <= 1'b1;
                            state      <= S_LOCK;
                        end else if (op == OP_SPAWN) begin
                            game_over <= 1'b1;
                            state     <= S_GAMEOVER;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_LOCK: begin
                    if (lock_valid && lock_ready) begin
                        lock_valid    <= 1'b0;
                        pieces_locked <= pieces_locked + 16'd1;
                        pend_down     <= 1'b0;
                        state         <= S_SPAWN;
                    end
                end
                S_GAMEOVER: begin
                    chk_valid  <= 1'b0;
                    lock_valid <= 1'b0;
                end
                default: state <= S_SPAWN;
            endcase

            // Placed after the selection logic so a pulse landing on a selection cycle survives it.
            if (state != S_GAMEOVER) begin
                if (tick)       pend_down  <= 1'b1;
                if (move_left)  pend_left  <= 1'b1;
                if (move_right) pend_right <= 1'b1;
                if (hard_drop)  pend_drop  <= 1'b1;
            end
        end
    end
endmodule
